// File: rtl/ysyx_22050039_ifu_fetch_if.sv
// Fetch-stage bundle: EXU redirect, memory read port and the {inst, pc} output handshake.
// master = fetch unit, slave = surrounding system (memory + EXU).
interface ysyx_22050039_ifu_fetch_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [XLEN-1:0]     mem_req_addr;
    logic                mem_resp_valid;
    logic [XLEN-1:0]     mem_resp_data;
    logic                out_valid;
    logic                out_ready;
    logic [INST_LEN-1:0] out_inst;
    logic [XLEN-1:0]     out_pc;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc
    );
endinterface

// File: rtl/ysyx_22050039_ifu_fetch.sv
// Instruction fetch: one outstanding 8-byte read, pc[2] half select, small instruction FIFO.
// Optional perf counters are compiled in with `define YSYX_22050039_IFU_PERF_EN.
module ysyx_22050039_ifu_fetch #(
    parameter int              XLEN       = 64,
    parameter int              INST_LEN   = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h8000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22050039_ifu_fetch_if.master bus
`ifdef YSYX_22050039_IFU_PERF_EN
    ,
    output logic [63:0]               perf_fetch_cnt_o,
    output logic [63:0]               perf_stall_cnt_o
`endif
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] ALIGN8  = ~XLEN'(7);
    localparam logic [XLEN-1:0] ALIGN4  = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e              state_q;
    logic [XLEN-1:0]     fetch_pc_q;
    logic [XLEN-1:0]     req_pc_q;
    logic                drop_q;
    logic                req_valid_q;
    logic [XLEN-1:0]     req_addr_q;

    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [INST_LEN-1:0] inst_mem [FIFO_DEPTH];
    logic [XLEN-1:0]     pc_mem   [FIFO_DEPTH];

    logic                out_valid;
    logic                pop;
    logic                push;
    logic [CNT_W-1:0]    count_after;
    logic [INST_LEN-1:0] inst_sel;
    logic [XLEN-1:0]     redir_pc;

    assign out_valid   = (count_q != '0);
    assign pop         = out_valid & bus.out_ready;
    // A response arriving under a redirect or while draining a stale request never enters the FIFO.
    assign push        = (state_q == S_WAIT) & bus.mem_resp_valid & ~drop_q & ~bus.redirect_valid;
    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);
    assign inst_sel    = req_pc_q[2] ? bus.mem_resp_data[XLEN-1:INST_LEN]
                                     : bus.mem_resp_data[INST_LEN-1:0];
    assign redir_pc    = bus.redirect_pc & ALIGN4;

    // NOTE: the whole FSM, including its registered request outputs, lives in one always_ff
    // with non-blocking assignments only, so every output is a flop and nothing can latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc_q <= redir_pc;
            if ((state_q == S_WAIT) && !bus.mem_resp_valid) begin
                drop_q      <= 1'b1;
                req_valid_q <= 1'b0;
                req_addr_q  <= '0;
            end else begin
                state_q     <= S_REQ;
                drop_q      <= 1'b0;
                req_valid_q <= 1'b1;
                req_addr_q  <= redir_pc & ALIGN8;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (count_q < DEPTH_C) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= fetch_pc_q & ALIGN8;
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        state_q     <= S_WAIT;
                        req_pc_q    <= fetch_pc_q;
                        fetch_pc_q  <= fetch_pc_q + XLEN'(4);
                        req_valid_q <= 1'b0;
                        req_addr_q  <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        drop_q <= 1'b0;
                        if (drop_q || (count_after < DEPTH_C)) begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                            req_addr_q  <= fetch_pc_q & ALIGN8;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Redirect flushes whatever remains after this cycle's pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_after;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by count_q and the
    // outputs are forced to zero when empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= inst_sel;
            pc_mem[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.out_valid     = out_valid;
    assign bus.out_inst      = out_valid ? inst_mem[rd_ptr_q] : '0;
    assign bus.out_pc        = out_valid ? pc_mem[rd_ptr_q]   : '0;

`ifdef YSYX_22050039_IFU_PERF_EN
    logic [63:0] perf_fetch_q;
    logic [63:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop)                         perf_fetch_q <= perf_fetch_q + 64'd1;
            if (!out_valid && bus.out_ready) perf_stall_q <= perf_stall_q + 64'd1;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22050039_ifu_fetch.sv
// Self-checking bench for ysyx_22050039_ifu_fetch: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_ysyx_22050039_ifu_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050039_ifu_fetch_if bus ();

`ifdef YSYX_22050039_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
  ysyx_22050039_ifu_fetch dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_fetch_cnt_o(perf_fetch_cnt), .perf_stall_cnt_o(perf_stall_cnt)
  );
`else
  ysyx_22050039_ifu_fetch dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: instruction buffer as a queue, fetch progress as a few flags.
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } entry_t;

  entry_t      m_q[$];
  logic [63:0] m_fetch_pc;
  logic [63:0] m_req_pc;
  bit          m_req;
  bit          m_wait;
  bit          m_drop;
  logic [63:0] m_pops;
  logic [63:0] m_stalls;

  logic [63:0] obs_addr[$];
  logic [63:0] obs_pc[$];
  logic [31:0] obs_inst[$];

  function automatic void model_reset();
    m_q.delete();
    m_fetch_pc = RESET_PC;
    m_req_pc   = '0;
    m_req      = 1'b0;
    m_wait     = 1'b0;
    m_drop     = 1'b0;
    m_pops     = '0;
    m_stalls   = '0;
  endfunction

  function automatic void model_step(input bit rv, input logic [63:0] rpc, input bit rq_rdy,
                                     input bit rs_v, input logic [63:0] rs_d, input bit o_rdy);
    bit idle_room;
    bit pop;
    idle_room = m_q.size() < DEPTH;
    pop       = (m_q.size() != 0) && o_rdy;
    if (pop) m_pops++;
    if ((m_q.size() == 0) && o_rdy) m_stalls++;
    if (rv) begin
      m_q.delete();
      m_fetch_pc = rpc & ~64'd3;
      if (m_wait && !rs_v) begin
        m_drop = 1'b1;
        m_req  = 1'b0;
      end else begin
        m_wait = 1'b0;
        m_drop = 1'b0;
        m_req  = 1'b1;
      end
      return;
    end
    if (pop) void'(m_q.pop_front());
    if (m_wait) begin
      if (rs_v) begin
        m_wait = 1'b0;
        if (m_drop) begin
          m_drop = 1'b0;
          m_req  = 1'b1;
        end else begin
          m_q.push_back('{inst: (m_req_pc[2] ? rs_d[63:32] : rs_d[31:0]), pc: m_req_pc});
          m_req = m_q.size() < DEPTH;
        end
      end
    end else if (m_req) begin
      if (rq_rdy) begin
        m_req      = 1'b0;
        m_wait     = 1'b1;
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end else begin
      m_req = idle_room;
    end
  endfunction

  task automatic drive(input bit rv, input logic [63:0] rpc, input bit rq_rdy,
                       input bit rs_v, input logic [63:0] rs_d, input bit o_rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.mem_req_ready  = rq_rdy;
    bus.mem_resp_valid = rs_v;
    bus.mem_resp_data  = rs_d;
    bus.out_ready      = o_rdy;
  endtask

  // Check the state settled by the last posedge, then apply inputs for the next one.
  task automatic cycle(input bit rv, input logic [63:0] rpc, input bit rq_rdy,
                       input bit rs_v, input logic [63:0] rs_d, input bit o_rdy);
    @(negedge clk);
    check("req_valid", bus.mem_req_valid, m_req);
    check("req_addr",  bus.mem_req_addr, m_req ? (m_fetch_pc & ~64'd7) : 64'd0);
    check("out_valid", bus.out_valid, m_q.size() != 0);
    check("out_inst",  bus.out_inst, (m_q.size() != 0) ? m_q[0].inst : 32'd0);
    check("out_pc",    bus.out_pc, (m_q.size() != 0) ? m_q[0].pc : 64'd0);
`ifdef YSYX_22050039_IFU_PERF_EN
    check("perf_fetch", perf_fetch_cnt, m_pops);
    check("perf_stall", perf_stall_cnt, m_stalls);
`endif
    if (bus.mem_req_valid && rq_rdy && !rv) obs_addr.push_back(bus.mem_req_addr);
    if (bus.out_valid && o_rdy) begin
      obs_pc.push_back(bus.out_pc);
      obs_inst.push_back(bus.out_inst);
    end
    drive(rv, rpc, rq_rdy, rs_v, rs_d, o_rdy);
    model_step(rv, rpc, rq_rdy, rs_v, rs_d, o_rdy);
  endtask

  task automatic release_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    model_step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    obs_addr.delete();
    obs_pc.delete();
    obs_inst.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    release_reset();
  endtask

  localparam logic [63:0] D1   = 64'h1111_1111_0000_0013;
  localparam logic [63:0] BAD  = 64'hdead_beef_dead_beef;
  localparam logic [63:0] GOOD = 64'hcafe_f00d_1234_5678;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    check("rst_req_valid", bus.mem_req_valid, 64'd0);
    check("rst_req_addr",  bus.mem_req_addr, 64'd0);
    check("rst_out_valid", bus.out_valid, 64'd0);

    // Streaming with an always-ready memory and consumer.
    do_reset();
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b1, D1, 1'b1);
    check("t1_addr0", obs_addr[0], 64'h8000_0000);
    check("t1_addr1", obs_addr[1], 64'h8000_0000);
    check("t1_addr2", obs_addr[2], 64'h8000_0008);
    check("t1_pc0",   obs_pc[0], 64'h8000_0000);
    check("t1_pc1",   obs_pc[1], 64'h8000_0004);
    check("t1_pc2",   obs_pc[2], 64'h8000_0008);
    check("t1_inst0", obs_inst[0], 64'h0000_0013);
    check("t1_inst1", obs_inst[1], 64'h1111_1111);

    // Backpressure fills the buffer and stops requests.
    do_reset();
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1, D1, 1'b0);
    check("t2_outv",  bus.out_valid, 64'd1);
    check("t2_reqv",  bus.mem_req_valid, 64'd0);
    check("t2_nreq",  obs_addr.size(), 64'd2);
    obs_addr.delete();
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b1, D1, 1'b1);
    check("t2_resume", obs_addr[0], 64'h8000_0008);

    // Redirect while a read is in flight: its response must be dropped.
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 64'h8000_0104, 1'b0, 1'b0, '0, 1'b1);
    obs_addr.delete();
    obs_pc.delete();
    obs_inst.delete();
    cycle(1'b0, '0, 1'b0, 1'b1, BAD, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1, GOOD, 1'b1);
    check("t3_addr", obs_addr[0], 64'h8000_0100);
    check("t3_pc",   obs_pc[0], 64'h8000_0104);
    check("t3_inst", obs_inst[0], 64'hcafe_f00d);

    // Redirect coinciding with a pop from a full buffer.
    do_reset();
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b1, D1, 1'b0);
    obs_pc.delete();
    cycle(1'b1, 64'h8000_0200, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("t4_outv",  bus.out_valid, 64'd0);
    check("t4_npop",  obs_pc.size(), 64'd1);
    check("t4_pc",    obs_pc[0], 64'h8000_0000);

    // Asynchronous reset while waiting with a buffered instruction.
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, D1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t5_req_valid", bus.mem_req_valid, 64'd0);
    check("t5_req_addr",  bus.mem_req_addr, 64'd0);
    check("t5_out_valid", bus.out_valid, 64'd0);
    check("t5_out_inst",  bus.out_inst, 64'd0);
    check("t5_out_pc",    bus.out_pc, 64'd0);
    release_reset();
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, D1, 1'b1);
    check("t5_addr0", obs_addr[0], 64'h8000_0000);

    // Random traffic, including responses outside WAIT and PC wrap-around.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit          rv;
      logic [63:0] rpc;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 64'hffff_ffff_ffff_fffc : {$urandom, $urandom};
      cycle(rv, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
